// File: rtl/dispense_scheduler_if.sv
// Request/grant and pulse-train signal bundle shared by the scheduler and its requesters.
// The master side is the scheduler; the slave side is the requester/clockdiv side.
interface dispense_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 9
);
  logic                     tick;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   amount;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  logic                     out;
  logic                     done;
  logic [1:0]               done_id;

  modport master (
    input  tick, req, amount,
    output grant, busy, out, done, done_id
  );

  modport slave (
    output tick, req, amount,
    input  grant, busy, out, done, done_id
  );
endinterface

// File: rtl/dispense_scheduler.sv
// Round-robin scheduler sharing one tick-paced pulse-train output between up to four requesters.
// Each accepted job drives out for exactly amount ticks, pulses done, then idles GAP ticks.
module dispense_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 9,
  parameter int GAP   = 2
) (
  input  logic                 sysclk,
  input  logic                 rst,
  dispense_scheduler_if.master bus
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [WIDTH-1:0] REM_ONE  = WIDTH'(1);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP);
  localparam logic [1:0]       PTR_RST  = 2'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           id_q, id_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [1:0]           done_id_q, done_id_d;

  logic [3:0]           req_pad_s;
  logic [1:0]           cand_s;
  logic [1:0]           sel_s;
  logic                 any_req_s;
  logic [WIDTH-1:0]     amt_sel_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (idx == 2'(i));
    end
    return v;
  endfunction

  // Arbitration: first set request searching upward from the last grant, wrapping.
  always_comb begin
    req_pad_s             = 4'b0000;
    req_pad_s[N_REQ-1:0]  = bus.req;
    cand_s                = 2'd0;
    sel_s                 = 2'd0;
    any_req_s             = 1'b0;
    amt_sel_s             = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s    = 2'((int'(ptr_q) + k) % N_REQ);
      sel_s     = (!any_req_s && req_pad_s[cand_s]) ? cand_s : sel_s;
      any_req_s = any_req_s | req_pad_s[cand_s];
    end
    for (int i = 0; i < N_REQ; i++) begin
      amt_sel_s = (sel_s == 2'(i)) ? bus.amount[i*WIDTH +: WIDTH] : amt_sel_s;
    end
  end

  // Next-state and registered-output logic for the IDLE/RUN/GAP sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    grant_d   = '0;
    out_d     = out_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_d = onehot(sel_s);
          ptr_d   = sel_s;
          id_d    = sel_s;
          rem_d   = amt_sel_s;
          if (amt_sel_s != '0) begin
            out_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            // Zero-amount job completes on its own grant edge.
            out_d     = 1'b0;
            done_d    = 1'b1;
            done_id_d = sel_s;
            if (GAP == 0) begin
              state_d = ST_IDLE;
              gap_d   = '0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.tick) begin
          if (rem_q > REM_ONE) begin
            rem_d = rem_q - REM_ONE;
          end else begin
            out_d     = 1'b0;
            done_d    = 1'b1;
            done_id_d = id_q;
            rem_d     = '0;
            if (GAP == 0) begin
              state_d = ST_IDLE;
              gap_d   = '0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end else begin
          rem_d = rem_q;
        end
      end
      ST_GAP: begin
        if (bus.tick) begin
          if (gap_q <= GAP_ONE) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        rem_d   = '0;
        gap_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any job without a done pulse.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      id_q      <= 2'd0;
      rem_q     <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_id_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      grant_q   <= grant_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.out     = out_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Round-robin scheduler that shares one pulse-train output channel between up to four requesters. Each requester presents a dispense amount (in tick units) and holds a request. The scheduler grants one requester at a time, drives `out` high for exactly that many `tick` enables, then signals completion and enforces an idle gap. It sits between the front-panel/coin-entry logic and the clockdiv-paced output, with `tick` driven by the clockdiv pulse.

## Interface

- `N_REQ`, default 4: number of requesters; supported range 2..4.
- `WIDTH`, default 9: amount width in bits.
- `GAP`, default 2: idle ticks between consecutive jobs; 0 is legal.

- `sysclk`, input, 1: single system clock; every register updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `tick`, input, 1: one-cycle rate enable from clockdiv, synchronous to `sysclk`.
- `req`, input, N_REQ: request per requester; level, held until granted.
- `amount`, input, N_REQ*WIDTH: amount for requester i in bits [i*WIDTH +: WIDTH].
- `grant`, output, N_REQ: one-hot, one-cycle pulse when a job is accepted.
- `busy`, output, 1: high in RUN and GAP.
- `out`, output, 1: pulse-train output; high for exactly `amount` ticks per job.
- `done`, output, 1: one-cycle pulse at job completion.
- `done_id`, output, 2: index of the completed job; valid while `done`=1, holds its value otherwise.

## Operation

- States: IDLE, RUN, GAP.
- Reset:
  - `grant`=0, `busy`=0, `out`=0, `done`=0, `done_id`=0.
  - Remaining counter = 0, gap counter = 0, state = IDLE.
  - Last-grant pointer = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any `req` is set, pick the first set bit searching upward from pointer+1, wrapping modulo N_REQ.
  - On that edge: `grant[i]`<=1, pointer<=i, remaining<=`amount[i]` (sampled this cycle), id<=i.
  - If `amount[i]`≠0: `out`<=1 and state<=RUN.
  - If `amount[i]`=0: `out` stays 0, `done`<=1 and `done_id`<=i on the same edge, state<=GAP (or IDLE if GAP=0).
- RUN:
  - `tick` with remaining>1: decrement remaining.
  - `tick` with remaining==1: `out`<=0, `done`<=1, `done_id`<=id, remaining<=0, gap counter<=GAP, state<=GAP. If GAP=0, go to IDLE instead.
  - `req` is ignored while in RUN.
- GAP:
  - On each `tick`: decrement the gap counter.
  - On the tick where the counter is 1: state<=IDLE.
  - `req` is ignored.
- Ticks that arrive in IDLE, or on the grant edge, are not counted toward a job.
- A requester that drops `req` before being granted is skipped. No request queueing.
- The requester must deassert `req` after its `grant` pulse. If `req` is still high when the scheduler returns to IDLE, it is a new job.
- Arithmetic:
  - Remaining counter is WIDTH bits and never wraps.
  - Maximum amount is 2^WIDTH-1 (511 at default).
  - Gap counter width is clog2(GAP+1).
- `rst` asserted in any state returns all registers to reset values on that edge, including the pointer. The in-progress job is abandoned and no `done` is issued.

## Timing

- Grant latency: `req` high in IDLE at cycle t gives `grant` and `out` high at t+1.
- `out` width: `out` rises on the grant edge and falls on the edge sampling the amount-th `tick` in RUN. With `tick` continuously high and amount A, `out` is high for exactly A cycles.
- `done`: rises on the same edge `out` falls, lasts one cycle.
- `busy`: high from the grant edge until the edge entering IDLE.
- Back-to-back throughput: the next grant comes at the earliest one cycle after the GAP-th tick following `done`. With GAP=0, the next grant comes one cycle after `done`.
- `done` and `grant` never overlap except for zero-amount jobs, where both pulse on the same edge.

## Test plan

- Single request, timed output: `req[0]`=1, amount 88, `tick` every 4 cycles. Require `grant`=0001 for 1 cycle, `out` high for 88 ticks (352 cycles ±3), then `done`=1 with `done_id`=0.
- Round-robin order: `req`=0111 with amounts 3, 5, 7, requesters re-asserting after each grant; `tick` constant. Require grant order 0, 1, 2, 0 and `out` widths 3, 5, 7 cycles, each separated by a 2-cycle gap plus 1 cycle.
- Zero amount: `req[2]`=1, amount 0. Require `grant[2]` and `done` on the same cycle with `done_id`=2, `out` never high, `busy` high for 2 ticks.
- Reset mid-job: `rst` for 1 cycle during RUN of a 100-tick job. Require all outputs 0 on the next cycle, no `done`, and requester 0 wins the next contention.
- Maximum amount: amount 511, `tick` constant. Require `out` high for exactly 511 cycles with no wrap, followed by `done`.
- Minimum gap: GAP=0, amount 1, `req[1]` held high, `tick` constant. Require `out` high 1 cycle, `done`, then a new `grant[1]` exactly 1 cycle later.
